// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin arbiter sharing one uart_tx serializer among N_REQ byte producers
module uart_tx_arb #(
    parameter  int N_REQ       = 4,
    parameter  int ACK_TIMEOUT = 4,
    localparam int IDW         = $clog2(N_REQ)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_REQ-1:0]   i_req_valid,
    input  logic [8*N_REQ-1:0] i_req_data,
    output logic [N_REQ-1:0]   o_req_ready,
    output logic               o_tx_start,
    output logic [7:0]         o_tx_data,
    input  logic               i_tx_busy,
    output logic [IDW-1:0]     o_grant_id,
    output logic               o_ctrl_busy,
    output logic               o_ack_err
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_ACK   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [IDW-1:0] r_last;
    logic [IDW-1:0] r_grant_id;
    logic [7:0]     r_tx_data;
    logic [CW-1:0]  r_cnt;
    logic           r_tx_start;
    logic           r_ack_err;

    logic [IDW-1:0] w_win;
    logic [7:0]     w_win_data;
    logic           w_found;
    logic           w_grant;
    logic           w_timeout;
    int             w_best;

    // Winner: the valid requester with the smallest rotational distance past r_last
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_best  = N_REQ;
        for (int i = 0; i < N_REQ; i++) begin
            if (i_req_valid[i] && (((i + N_REQ - 1 - int'(r_last)) % N_REQ) < w_best)) begin
                w_best  = (i + N_REQ - 1 - int'(r_last)) % N_REQ;
                w_found = 1'b1;
                w_win   = IDW'(i);
            end
        end
    end

    // Lane mux for the winning requester's byte
    always_comb begin
        w_win_data = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win == IDW'(i)) begin
                w_win_data = i_req_data[8*i +: 8];
            end
        end
    end

    assign w_grant     = (r_state == S_IDLE) && !i_tx_busy && w_found;
    assign w_timeout   = (r_state == S_ACK) && !i_tx_busy && (r_cnt == CW'(ACK_TIMEOUT - 1));
    assign o_req_ready = w_grant ? (N_REQ'(1) << w_win) : '0;
    assign o_ctrl_busy = (r_state != S_IDLE);
    assign o_tx_start  = r_tx_start;
    assign o_tx_data   = r_tx_data;
    assign o_grant_id  = r_grant_id;
    assign o_ack_err   = r_ack_err;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: one frame in flight, dropped on missing acknowledge
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_grant) w_state_nxt = S_START;
            S_START: w_state_nxt = S_ACK;
            S_ACK: begin
                if (i_tx_busy) begin
                    w_state_nxt = S_DRAIN;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DRAIN: if (!i_tx_busy) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Registered outputs, round-robin pointer and acknowledge counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
            r_grant_id <= '0;
            r_ack_err  <= 1'b0;
            r_last     <= IDW'(N_REQ - 1);
            r_cnt      <= '0;
        end else begin
            r_tx_start <= w_grant;
            r_ack_err  <= w_timeout;
            if (w_grant) begin
                r_tx_data  <= w_win_data;
                r_grant_id <= w_win;
                r_last     <= w_win;
            end
            if (r_state == S_START) begin
                r_cnt <= '0;
            end else if ((r_state == S_ACK) && !i_tx_busy) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - randomized bench for uart_tx_arb against a timeline reference model
module tb_uart_tx_arb;

    localparam int N     = 4;
    localparam int TO    = 4;
    localparam int IW    = 2;
    localparam int N_CYC = 4000;
    localparam int A_END = 120;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy;
    logic [IW-1:0]  grant_id;
    logic           ctrl_busy;
    logic           ack_err;

    uart_tx_arb #(.N_REQ(N), .ACK_TIMEOUT(TO)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .o_req_ready (req_ready),
        .o_tx_start  (tx_start),
        .o_tx_data   (tx_data),
        .i_tx_busy   (tx_busy),
        .o_grant_id  (grant_id),
        .o_ctrl_busy (ctrl_busy),
        .o_ack_err   (ack_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Reference model: frame timeline expressed with cycle stamps
    int         m_ptr;
    bit         m_inflight;
    bit         m_drain;
    bit         m_start;
    bit         m_err;
    int         m_tstart;
    logic [7:0] m_data;
    int         m_gid;

    // Producers and serializer model
    bit         p_valid [N];
    logic [7:0] p_data  [N];
    int         u_wait, u_len, u_spur;
    int         rst_left;

    // Per-cycle samples
    bit             s_rst, s_busy, s_start;
    logic [N-1:0]   s_valid, s_ready, e_ready;
    logic [8*N-1:0] s_data;

    logic [7:0] seq_data [5];
    int         seq_gid  [5];
    int         seq_n;
    int         n_ackerr;

    task automatic model_reset();
        m_ptr      = N - 1;
        m_inflight = 0;
        m_drain    = 0;
        m_start    = 0;
        m_err      = 0;
        m_tstart   = -1;
        m_data     = 8'h00;
        m_gid      = 0;
    endtask

    // First valid requester scanning ptr+1, ptr+2, ... modulo N
    function automatic logic [N-1:0] model_ready(input logic [N-1:0] v, input int ptr,
                                                 input bit idle, input bit busy);
        logic [N-1:0] r;
        bit           found;
        int           idx;
        r     = '0;
        found = 0;
        if (idle && !busy) begin
            for (int k = 1; k <= N; k++) begin
                idx = (ptr + k) % N;
                if (!found && v[IW'(idx)]) begin
                    r[IW'(idx)] = 1'b1;
                    found       = 1;
                end
            end
        end
        return r;
    endfunction

    task automatic model_step();
        bit nxt_start, nxt_err;
        nxt_start = 0;
        nxt_err   = 0;
        if (m_inflight) begin
            if (m_drain) begin
                if (!s_busy) m_inflight = 0;
            end else if (cyc > m_tstart) begin
                if (s_busy) begin
                    m_drain = 1;
                end else if (cyc - m_tstart == TO) begin
                    m_inflight = 0;
                    nxt_err    = 1;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (e_ready[i] && s_valid[i]) begin
                    m_data     = 8'(s_data >> (8 * i));
                    m_gid      = i;
                    m_ptr      = i;
                    m_inflight = 1;
                    m_drain    = 0;
                    m_tstart   = cyc + 1;
                    nxt_start  = 1;
                end
            end
        end
        m_start = nxt_start;
        m_err   = nxt_err;
    endtask

    task automatic drive(input bit phase_a);
        if (cyc < 2) begin
            rst = 1'b1;
        end else if (rst_left > 0) begin
            rst = 1'b1;
            rst_left--;
        end else begin
            rst = 1'b0;
            if (!phase_a && $urandom_range(0, 199) == 0) begin
                rst      = 1'b1;
                rst_left = $urandom_range(0, 1);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (cyc >= 2) begin
                if (!p_valid[i]) begin
                    if (phase_a) begin
                        p_valid[i] = 1;
                        p_data[i]  = 8'(8'h10 + i);
                    end else if ($urandom_range(0, 2) == 0) begin
                        p_valid[i] = 1;
                        p_data[i]  = 8'($urandom);
                    end
                end else if (!phase_a && $urandom_range(0, 39) == 0) begin
                    p_valid[i] = 0;
                end
            end
            req_valid[i]      = p_valid[i];
            req_data[8*i +: 8] = p_data[i];
        end
        if (!phase_a && u_wait == 0 && u_len == 0 && u_spur == 0 && !m_inflight &&
            $urandom_range(0, 15) == 0) begin
            u_spur = $urandom_range(1, 4);
        end
        if (u_wait > 0) begin
            tx_busy = 1'b0;
            u_wait--;
        end else if (u_len > 0) begin
            tx_busy = 1'b1;
            u_len--;
        end else if (u_spur > 0) begin
            tx_busy = 1'b1;
            u_spur--;
        end else begin
            tx_busy = 1'b0;
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        tx_busy   = 1'b0;
        u_wait    = 0;
        u_len     = 0;
        u_spur    = 0;
        rst_left  = 0;
        seq_n     = 0;
        n_ackerr  = 0;
        for (int i = 0; i < 5; i++) begin
            seq_data[i] = 8'h00;
            seq_gid[i]  = -1;
        end
        for (int i = 0; i < N; i++) begin
            p_valid[i] = 0;
            p_data[i]  = 8'h00;
        end
        model_reset();

        for (int c = 0; c < N_CYC; c++) begin
            drive(cyc < A_END);

            @(negedge clk);
            s_rst   = rst;
            s_valid = req_valid;
            s_data  = req_data;
            s_busy  = tx_busy;
            s_ready = req_ready;
            s_start = tx_start;
            e_ready = model_ready(req_valid, m_ptr, !m_inflight, tx_busy);
            check_eq("req_ready", 32'(req_ready), 32'(e_ready));
            check_eq("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
            check_eq("ctrl_busy", 32'(ctrl_busy), 32'(m_inflight));
            check_eq("tx_start", 32'(tx_start), 32'(m_start));
            check_eq("ack_err", 32'(ack_err), 32'(m_err));
            check_eq("tx_data", 32'(tx_data), 32'(m_data));
            check_eq("grant_id", 32'(grant_id), 32'(m_gid));
            if (ack_err === 1'b1) n_ackerr++;
            if (cyc < A_END && tx_start === 1'b1 && seq_n < 5) begin
                seq_data[seq_n] = tx_data;
                seq_gid[seq_n]  = int'(grant_id);
                seq_n++;
            end

            @(posedge clk);
            if (s_rst) model_reset();
            else       model_step();
            for (int i = 0; i < N; i++) begin
                if (!s_rst && s_ready[i] && s_valid[i]) p_valid[i] = 0;
            end
            if (s_start && u_wait == 0 && u_len == 0) begin
                if (cyc < A_END) begin
                    u_wait = 0;
                    u_len  = 12;
                end else if ($urandom_range(0, 7) != 0) begin
                    u_wait = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO + 1) : 0;
                    u_len  = $urandom_range(1, 14);
                end
            end
            cyc++;
            #1;
        end

        check_eq("contention_frames", 32'(seq_n >= 5), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check_eq("contention_data", 32'(seq_data[i]), 32'(8'h10 + (i % N)));
            check_eq("contention_gid", 32'(seq_gid[i]), 32'(i % N));
        end
        check_eq("saw_ack_err", 32'(n_ackerr > 0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
Round-robin arbiter that shares one uart_tx serializer among N_REQ byte producers.
- Accepts one byte at a time from a requester using a valid/ready handshake.
- Drives the serializer's start/data_in inputs and tracks its busy output through each frame.
- Sits between the system's message sources and the single uart_tx instance. It guarantees one frame in flight and a fair share of the line.

Parameters:
N_REQ, 4, number of requesters (2..8)
ACK_TIMEOUT, 4, max cycles to wait for tx_busy to rise after tx_start (>=1)
Derived: IDW = $clog2(N_REQ).

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  N_REQ  requester i has a byte on its lane
req_data  in  8*N_REQ  flattened lanes; requester i at [8i+7:8i]
req_ready  out  N_REQ  one-hot; requester i's byte is accepted this cycle
tx_start  out  1  to uart_tx.start, one-cycle pulse
tx_data  out  8  to uart_tx.data_in
tx_busy  in  1  from uart_tx.busy
grant_id  out  IDW  index of the requester whose byte is in flight
ctrl_busy  out  1  high whenever state != IDLE
ack_err  out  1  one-cycle pulse: serializer never acknowledged start

Behaviour:
Reset values:
- state=IDLE, tx_start=0, tx_data=0x00, grant_id=0, ack_err=0.
- Round-robin pointer last=N_REQ-1, so requester 0 has top priority first.
- Timeout counter=0.

req_ready:
- Combinational: req_ready[w]=1 only when state==IDLE, tx_busy==0, any req_valid, and w is the winner.
- Handshake completes on req_valid[w] && req_ready[w] in the same cycle.
- A requester must hold req_data stable while valid and not ready.

Winner: first i with req_valid[i]=1, scanning last+1, last+2, ... modulo N_REQ.

FSM (all outputs registered except req_ready and ctrl_busy):
- IDLE:
  - On a grant: tx_data<=lane w, grant_id<=w, last<=w, go to START.
  - No grant if tx_busy==1 or no valid.
- START:
  - tx_start=1 for exactly this one cycle; counter<=0; go to ACK.
- ACK:
  - If tx_busy==1, go to DRAIN.
  - Otherwise counter increments.
  - On the ACK_TIMEOUT-th consecutive low cycle, go to IDLE and set ack_err=1 for the first IDLE cycle.
  - The pointer stays advanced past the failed requester. The byte is dropped, not retried.
- DRAIN:
  - Hold while tx_busy==1; go to IDLE on the first tx_busy==0 cycle.

Holding and latency:
- tx_data and grant_id hold from capture until the next grant; they do not change during a frame.
- Latency from handshake to tx_start is 1 cycle.
- Minimum gap is one IDLE cycle between tx_busy falling and the next tx_start-1.
- req_valid changes after acceptance have no effect on the frame in flight.
- Exactly one req_ready bit is high in any cycle, or none.

Reset mid-operation:
- Any state goes to IDLE on the next edge with reset values; tx_start is low the cycle after rst.
- The pointer resets, so requester 0 regains top priority.

Test Plan:
1. Single byte: rst 2 cycles, then req_valid=0001, lane0=0x41 -> req_ready=0001 same cycle; next cycle tx_start=1, tx_data=0x41, grant_id=0; no further req_ready until tx_busy falls; ctrl_busy low again one cycle after tx_busy falls.
2. Full contention: req_valid=1111 held, lanes 0x10/0x11/0x12/0x13, uart_tx model busy 12 cycles per frame -> tx_data sequence 0x10,0x11,0x12,0x13,0x10; grant_id 0,1,2,3,0; exactly one tx_start per frame.
3. Rotation: only req 2 valid (0x22) and granted; then req 1 and 2 valid (0x21/0x22) -> scan order is 3,0,1, so req 1 wins next with tx_data=0x21; req 2 follows.
4. Ack timeout: tx_busy tied 0, req 0 valid with 0x55 -> tx_start at T; ACK cycles T+1..T+4; ack_err=1 only at T+5; state IDLE at T+5; req 1 wins next if valid.
5. Reset mid-DRAIN: rst high for one cycle while tx_busy=1 -> next cycle tx_start=0, tx_data=0x00, grant_id=0, ctrl_busy=0; with req_valid=1001 after reset, req 0 is granted first.
6. Busy blocking: tx_busy forced 1 while state is IDLE and req_valid=0010 -> req_ready stays 0000; grant occurs in the first cycle tx_busy=0.
